// File: rtl/vga_timing_gen.sv
// Raster timing generator: beam position, PIPE-delayed sync/de, line/frame
// strobes and a wrapping frame counter. Everything freezes while ena is low.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE     = 2,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    output logic [9:0]         hpos,
    output logic [9:0]         vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame
);

    localparam int         H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DE_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_DE_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       SYNC_IDLE = ~SYNC_POL;

    logic [9:0]         hpos_q, hpos_d;
    logic [9:0]         vpos_q, vpos_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               de_raw_s, hs_raw_s, vs_raw_s;
    logic [PIPE-1:0]    de_pipe_q, de_pipe_d;
    logic [PIPE-1:0]    hs_pipe_q, hs_pipe_d;
    logic [PIPE-1:0]    vs_pipe_q, vs_pipe_d;

    // Next beam position and frame count
    always_comb begin
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        frame_d = frame_q;
        if (ena) begin
            if (hpos_q == H_LAST) begin
                hpos_d = 10'd0;
                if (vpos_q == V_LAST) begin
                    vpos_d  = 10'd0;
                    frame_d = frame_q + FRAME_W'(1'b1);
                end else begin
                    vpos_d = vpos_q + 10'd1;
                end
            end else begin
                hpos_d = hpos_q + 10'd1;
            end
        end else begin
            hpos_d  = hpos_q;
            vpos_d  = vpos_q;
            frame_d = frame_q;
        end
    end

    // Undelayed decode of the current raster position
    always_comb begin
        de_raw_s = (hpos_q < H_DE_END) && (vpos_q < V_DE_END);
        hs_raw_s = ((hpos_q >= HS_START) && (hpos_q < HS_END)) ? SYNC_POL : SYNC_IDLE;
        vs_raw_s = ((vpos_q >= VS_START) && (vpos_q < VS_END)) ? SYNC_POL : SYNC_IDLE;
    end

    // Delay line shift; stage PIPE-1 drives the outputs
    always_comb begin
        de_pipe_d = de_pipe_q;
        hs_pipe_d = hs_pipe_q;
        vs_pipe_d = vs_pipe_q;
        if (ena) begin
            de_pipe_d[0] = de_raw_s;
            hs_pipe_d[0] = hs_raw_s;
            vs_pipe_d[0] = vs_raw_s;
            for (int i = 1; i < PIPE; i++) begin
                de_pipe_d[i] = de_pipe_q[i-1];
                hs_pipe_d[i] = hs_pipe_q[i-1];
                vs_pipe_d[i] = vs_pipe_q[i-1];
            end
        end else begin
            de_pipe_d = de_pipe_q;
            hs_pipe_d = hs_pipe_q;
            vs_pipe_d = vs_pipe_q;
        end
    end

    // State registers with asynchronous reset to the idle raster
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q    <= 10'd0;
            vpos_q    <= 10'd0;
            frame_q   <= {FRAME_W{1'b0}};
            de_pipe_q <= {PIPE{1'b0}};
            hs_pipe_q <= {PIPE{SYNC_IDLE}};
            vs_pipe_q <= {PIPE{SYNC_IDLE}};
        end else begin
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            frame_q   <= frame_d;
            de_pipe_q <= de_pipe_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame       = frame_q;
    assign de          = de_pipe_q[PIPE-1];
    assign hsync       = hs_pipe_q[PIPE-1];
    assign vsync       = vs_pipe_q[PIPE-1];
    assign line_start  = (hpos_q == 10'd0);
    assign frame_start = (hpos_q == 10'd0) && (vpos_q == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line timing, freeze and reset;
// a tiny raster (15x8, PIPE=3, active-high syncs, FRAME_W=2) for frame behaviour.
module tb_vga_timing_gen;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [9:0] d_hpos, d_vpos;
    logic       d_hsync, d_vsync, d_de, d_line_start, d_frame_start;
    logic [7:0] d_frame;
    logic [9:0] s_hpos, s_vpos;
    logic       s_hsync, s_vsync, s_de, s_line_start, s_frame_start;
    logic [1:0] s_frame;

    int tests_run    = 0;
    int tests_failed = 0;

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .hpos(d_hpos), .vpos(d_vpos), .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
        .line_start(d_line_start), .frame_start(d_frame_start), .frame(d_frame)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .PIPE(3), .FRAME_W(2)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
        .line_start(s_line_start), .frame_start(s_frame_start), .frame(s_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {hsync, vsync, de} of the small instance t edges after reset release
    function automatic logic [2:0] s_expect(input int t);
        int p, h, v;
        if (t < 3) return 3'b000;
        p = (t - 3) % 120;
        h = p % 15;
        v = p / 15;
        return {logic'(h >= 10 && h < 13), logic'(v >= 5 && v < 7), logic'(h < 8 && v < 4)};
    endfunction

    task automatic test_reset();
        ena   = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_hpos", 32'(d_hpos), 32'd0);
        chk("reset_vpos", 32'(d_vpos), 32'd0);
        chk("reset_frame", 32'(d_frame), 32'd0);
        chk("reset_hsync", 32'(d_hsync), 32'd1);
        chk("reset_vsync", 32'(d_vsync), 32'd1);
        chk("reset_de", 32'(d_de), 32'd0);
        chk("reset_line_start", 32'(d_line_start), 32'd1);
        chk("reset_frame_start", 32'(d_frame_start), 32'd1);
        chk("reset_s_hsync", 32'(s_hsync), 32'd0);
        chk("reset_s_vsync", 32'(s_vsync), 32'd0);
        chk("reset_s_frame", 32'(s_frame), 32'd0);
        tick();
        chk("reset_held_hpos", 32'(d_hpos), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_counting();
        for (int k = 0; k < 800; k++) begin
            chk("count_hpos", 32'(d_hpos), 32'(k));
            chk("count_vpos", 32'(d_vpos), 32'd0);
            chk("count_line_start", 32'(d_line_start), 32'(k == 0));
            tick();
        end
        chk("wrap_hpos", 32'(d_hpos), 32'd0);
        chk("wrap_vpos", 32'(d_vpos), 32'd1);
        chk("wrap_line_start", 32'(d_line_start), 32'd1);
        chk("wrap_frame_start", 32'(d_frame_start), 32'd0);
    endtask

    task automatic test_sync_de();
        int de_cnt = 0;
        int hs_low = 0;
        for (int k = 0; k < 800; k++) begin
            chk("line_de", 32'(d_de), 32'(k >= 2 && k < 642));
            chk("line_hsync", 32'(d_hsync), 32'(!(k >= 658 && k < 754)));
            chk("line_vsync", 32'(d_vsync), 32'd1);
            if (d_de === 1'b1) de_cnt++;
            if (d_hsync === 1'b0) hs_low++;
            tick();
        end
        chk("de_count", 32'(de_cnt), 32'd640);
        chk("hsync_low_count", 32'(hs_low), 32'd96);
    endtask

    task automatic test_ena_freeze();
        for (int k = 0; k < 641; k++) tick();
        chk("pre_freeze_hpos", 32'(d_hpos), 32'd641);
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("freeze_hpos", 32'(d_hpos), 32'd641);
            chk("freeze_vpos", 32'(d_vpos), 32'd2);
            chk("freeze_de", 32'(d_de), 32'd1);
            chk("freeze_hsync", 32'(d_hsync), 32'd1);
            chk("freeze_line_start", 32'(d_line_start), 32'd0);
        end
        ena = 1'b1;
        tick();
        chk("resume_hpos", 32'(d_hpos), 32'd642);
        chk("resume_de", 32'(d_de), 32'd0);
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 575; k++) tick();
        chk("pre_rst_hpos", 32'(d_hpos), 32'd417);
        chk("pre_rst_vpos", 32'(d_vpos), 32'd3);
        chk("pre_rst_de", 32'(d_de), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hpos", 32'(d_hpos), 32'd0);
        chk("arst_vpos", 32'(d_vpos), 32'd0);
        chk("arst_frame", 32'(d_frame), 32'd0);
        chk("arst_hsync", 32'(d_hsync), 32'd1);
        chk("arst_vsync", 32'(d_vsync), 32'd1);
        chk("arst_de", 32'(d_de), 32'd0);
        tick();
        rst_n = 1'b1;
        chk("release_hpos", 32'(d_hpos), 32'd0);
        tick();
        chk("restart_hpos", 32'(d_hpos), 32'd1);
        chk("restart_vpos", 32'(d_vpos), 32'd0);
    endtask

    task automatic test_small_frames();
        int fs_cnt = 0;
        int de_cnt = 0;
        int vs_cnt = 0;
        logic [2:0] e;
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int t = 0; t <= 480; t++) begin
            e = s_expect(t);
            chk("s_hpos", 32'(s_hpos), 32'(t % 15));
            chk("s_vpos", 32'(s_vpos), 32'((t / 15) % 8));
            chk("s_frame", 32'(s_frame), 32'((t / 120) % 4));
            chk("s_frame_start", 32'(s_frame_start), 32'(t % 120 == 0));
            chk("s_hsync", 32'(s_hsync), 32'(e[2]));
            chk("s_vsync", 32'(s_vsync), 32'(e[1]));
            chk("s_de", 32'(s_de), 32'(e[0]));
            if (s_frame_start === 1'b1) fs_cnt++;
            if (s_de === 1'b1) de_cnt++;
            if (s_vsync === 1'b1) vs_cnt++;
            tick();
        end
        chk("s_frame_start_count", 32'(fs_cnt), 32'd5);
        chk("s_de_count", 32'(de_cnt), 32'd128);
        chk("s_vsync_count", 32'(vs_cnt), 32'd120);
    endtask

    initial begin
        test_reset();
        test_counting();
        test_sync_de();
        test_ena_freeze();
        test_async_reset();
        test_small_frames();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
